pipelined_rca_adder: RTL and testbench

//  Parametrised pipelined ripple-carry add/subtract unit. Splits a WIDTH-bit

---
 rtl/pipelined_rca_adder.sv | 141 ++++++++++++++
 tb/tb_pipelined_rca_adder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca_adder.sv
// pipelined_rca_adder
//   Pipelined ripple-carry add/subtract unit. A WIDTH-bit operation is split
//   into NSEG = WIDTH/SEG_W segments; segment k ripples in pipeline stage k, so
//   the critical path is an SEG_W-bit carry chain. Valid/ready handshake on
//   both sides with a single global advance; latency NSEG cycles, 1 op/cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/controls valid this cycle
//   in_ready   unit accepts operands this cycle (= !out_valid || out_ready)
//   a, b       WIDTH-bit operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: s = a + b + cin, 1: s = a - b - cin
//   out_valid  result valid
//   out_ready  downstream accepts result
//   s          result modulo 2^WIDTH
//   cout       add: carry-out; sub: 1 = no borrow
//   ovf        signed two's-complement overflow
module pipelined_rca_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG_W;

  if (SEG_W < 1 || WIDTH % SEG_W != 0) begin : g_bad_width
    $error("pipelined_rca_adder: WIDTH must be a non-zero multiple of SEG_W");
  end

  // Stage registers. Stage k holds the full operand words (upper segments are
  // the skew delay for later stages), the result word with segments 0..k
  // resolved, and the carry out of segment k. The last stage drives the outputs.
  logic [WIDTH-1:0] op_a [NSEG];
  logic [WIDTH-1:0] op_b [NSEG];
  logic [WIDTH-1:0] res  [NSEG];
  logic [NSEG-1:0]  carry;
  logic [NSEG-1:0]  vld;
  logic             ovf_q;

  // Per-stage inputs (from the ports for stage 0, from stage k-1 otherwise).
  logic [WIDTH-1:0] src_a    [NSEG];
  logic [WIDTH-1:0] src_b    [NSEG];
  logic [WIDTH-1:0] src_r    [NSEG];
  logic [WIDTH-1:0] res_next [NSEG];
  logic [NSEG-1:0]  src_c;
  logic [NSEG-1:0]  src_v;
  logic [NSEG-1:0]  co_next;
  logic [SEG_W:0]   seg_tot;
  logic             ovf_next;

  logic             adv;
  logic [WIDTH-1:0] b_mod;
  logic             cin_mod;

  // Subtraction as a + ~b + ~cin: borrow-in becomes an inverted carry-in.
  assign b_mod     = b ^ {WIDTH{sub}};
  assign cin_mod   = cin ^ sub;

  assign out_valid = vld[NSEG-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  assign s         = res[NSEG-1];
  assign cout      = carry[NSEG-1];
  assign ovf       = ovf_q;

  always_comb begin
    src_a[0] = a;
    src_b[0] = b_mod;
    src_r[0] = '0;
    src_c[0] = cin_mod;
    src_v[0] = in_valid;
    for (int unsigned k = 1; k < NSEG; k++) begin
      src_a[k] = op_a[k-1];
      src_b[k] = op_b[k-1];
      src_r[k] = res[k-1];
      src_c[k] = carry[k-1];
      src_v[k] = vld[k-1];
    end
  end

  always_comb begin
    seg_tot = '0;
    co_next = '0;
    for (int unsigned k = 0; k < NSEG; k++) begin
      seg_tot = {1'b0, src_a[k][k*SEG_W +: SEG_W]}
              + {1'b0, src_b[k][k*SEG_W +: SEG_W]}
              + {{SEG_W{1'b0}}, src_c[k]};
      res_next[k]                   = src_r[k];
      res_next[k][k*SEG_W +: SEG_W] = seg_tot[SEG_W-1:0];
      co_next[k]                    = seg_tot[SEG_W];
    end
  end

  // Carry into the MSB equals a ^ b ^ sum at that bit, so overflow can be taken
  // from the final segment without exposing its internal carry chain.
  assign ovf_next = src_a[NSEG-1][WIDTH-1] ^ src_b[NSEG-1][WIDTH-1]
                  ^ res_next[NSEG-1][WIDTH-1] ^ co_next[NSEG-1];

  // Data registers load only with a valid op so bubbles never disturb the
  // held result on s/cout/ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        op_a[k] <= '0;
        op_b[k] <= '0;
        res[k]  <= '0;
      end
      carry <= '0;
      vld   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        vld[k] <= src_v[k];
        if (src_v[k]) begin
          op_a[k]  <= src_a[k];
          op_b[k]  <= src_b[k];
          res[k]   <= res_next[k];
          carry[k] <= co_next[k];
        end
      end
      if (src_v[NSEG-1]) ovf_q <= ovf_next;
    end
  end

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// tb_pipelined_rca_adder
//   Directed and streaming checks of pipelined_rca_adder at WIDTH=32, SEG_W=8.
module tb_pipelined_rca_adder;

  localparam int WIDTH = 32;
  localparam int SEG_W = 8;
  localparam int LAT   = WIDTH / SEG_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  pipelined_rca_adder #(
    .WIDTH(WIDTH),
    .SEG_W(SEG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .cout     (cout),
    .ovf      (ovf)
  );

  // Reference: plain wide arithmetic, returns {ovf, cout, s}.
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mc, input logic ms);
    logic [32:0] w;
    longint      sr;
    logic        c;
    logic        o;
    if (!ms) begin
      w  = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
      c  = w[32];
      sr = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
    end else begin
      w  = {1'b0, ma} - {1'b0, mb} - {32'd0, mc};
      c  = !w[32];
      sr = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mc);
    end
    o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {o, c, w[31:0]};
  endfunction

  // Drives one op on an empty pipe and waits for its result (bounded).
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                        input logic ts, output logic [33:0] got, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = {ovf, cout, s};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if ({ovf, cout, s} !== 34'd0) $display("FAIL reset_result: got %h expected 0", {ovf, cout, s}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    out_ready = 1'b1;
  endtask

  task automatic test_add_carry();
    logic [33:0] got;
    int          lat;
    run_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, got, lat);
    n_total++; if (lat != LAT) $display("FAIL add_latency: got %0d expected %0d", lat, LAT); else n_pass++;
    n_total++; if (got[31:0] !== 32'h0) $display("FAIL add_s: got %h expected 00000000", got[31:0]); else n_pass++;
    n_total++; if (got[33:32] !== 2'b01) $display("FAIL add_flags: got ovf,cout=%b expected 01", got[33:32]); else n_pass++;
  endtask

  task automatic test_sub();
    logic [33:0] got;
    int          lat;
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, got, lat);
    n_total++; if (lat != LAT) $display("FAIL sub_latency: got %0d expected %0d", lat, LAT); else n_pass++;
    n_total++; if (got[31:0] !== 32'hFFFF_FFFE) $display("FAIL sub_s: got %h expected fffffffe", got[31:0]); else n_pass++;
    n_total++; if (got[33:32] !== 2'b00) $display("FAIL sub_flags: got ovf,cout=%b expected 00", got[33:32]); else n_pass++;
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, got, lat);
    n_total++; if (got[31:0] !== 32'h7FFF_FFFF) $display("FAIL sub_ovf_s: got %h expected 7fffffff", got[31:0]); else n_pass++;
    n_total++; if (got[33:32] !== 2'b11) $display("FAIL sub_ovf_flags: got ovf,cout=%b expected 11", got[33:32]); else n_pass++;
    // Equal after borrow-in: 0x10 - 0x0F - 1 = 0, no borrow.
    run_op(32'h0000_0010, 32'h0000_000F, 1'b1, 1'b1, got, lat);
    n_total++; if (got !== {2'b01, 32'h0}) $display("FAIL sub_borrow_in: got %h expected %h", got, {2'b01, 32'h0}); else n_pass++;
  endtask

  task automatic test_signed_ovf();
    logic [33:0] got;
    int          lat;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, got, lat);
    n_total++; if (got[31:0] !== 32'h8000_0000) $display("FAIL ovf_add_s: got %h expected 80000000", got[31:0]); else n_pass++;
    n_total++; if (got[33:32] !== 2'b10) $display("FAIL ovf_add_flags: got ovf,cout=%b expected 10", got[33:32]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp_q[$];
    logic [33:0] e;
    logic        exp_v;
    int          nops = 100;
    out_ready = 1'b1;
    for (int i = 0; i < nops + LAT + 4; i++) begin
      @(negedge clk);
      exp_v = (i >= LAT) && (i < nops + LAT);
      n_total++; if (out_valid !== exp_v) $display("FAIL b2b_valid[%0d]: got %b expected %b", i, out_valid, exp_v); else n_pass++;
      if (exp_v && out_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_total++; if ({ovf, cout, s} !== e) $display("FAIL b2b_data[%0d]: got %h expected %h", i, {ovf, cout, s}, e); else n_pass++;
      end
      if (i < nops) begin
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        if (i == 0) begin a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1; sub = 1'b0; end
        if (i == 1) begin a = 32'h0;         b = 32'h0; cin = 1'b1; sub = 1'b1; end
        in_valid = 1'b1;
        exp_q.push_back(model(a, b, cin, sub));
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] sb[$];
    logic [33:0] held;
    logic [33:0] e;
    logic        stall_prev = 1'b0;
    logic        accepted   = 1'b0;
    int          nops = 60;
    int          sent = 0;
    int          recv = 0;
    int          cyc  = 0;
    in_valid = 1'b0;
    while ((sent < nops || recv < sent) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stall_prev) begin
        n_total++;
        if (out_valid !== 1'b1 || {ovf, cout, s} !== held)
          $display("FAIL bp_stable[%0d]: got v=%b %h expected v=1 %h", cyc, out_valid, {ovf, cout, s}, held);
        else n_pass++;
      end
      if (accepted) in_valid = 1'b0;
      accepted = 1'b0;
      if (!in_valid && sent < nops && $urandom_range(0, 3) != 0) begin
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      n_total++;
      if (in_ready !== (!out_valid || out_ready))
        $display("FAIL bp_in_ready[%0d]: got %b expected %b", cyc, in_ready, (!out_valid || out_ready));
      else n_pass++;
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, cin, sub));
        sent++;
        accepted = 1'b1;
      end
      if (out_valid && out_ready) begin
        recv++;
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL bp_extra[%0d]: got result %h expected none", cyc, {ovf, cout, s});
        end else begin
          e = sb.pop_front();
          if ({ovf, cout, s} !== e) $display("FAIL bp_data[%0d]: got %h expected %h", cyc, {ovf, cout, s}, e);
          else n_pass++;
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {ovf, cout, s};
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_total++;
    if (sent != nops || recv != nops || sb.size() != 0)
      $display("FAIL bp_count: got sent=%0d recv=%0d pending=%0d expected %0d/%0d/0", sent, recv, sb.size(), nops, nops);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    logic [33:0] got;
    int          lat;
    int          stale;
    @(negedge clk);
    out_ready = 1'b1;
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 32'h0000_0001; b = 32'h0000_0002;
    @(negedge clk);
    a = 32'h0000_00F0; b = 32'h0000_000F;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_total++; if ({out_valid, s} !== {1'b1, 32'h2345_6789}) $display("FAIL mid_preload: got %b %h expected 1 23456789", out_valid, s); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if ({ovf, cout, s} !== 34'd0) $display("FAIL mid_result: got %h expected 0", {ovf, cout, s}); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b expected 1", in_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    n_total++; if (stale != 0) $display("FAIL mid_stale: got %0d valid cycles expected 0", stale); else n_pass++;
    run_op(32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, got, lat);
    n_total++; if (lat != LAT) $display("FAIL mid_latency: got %0d expected %0d", lat, LAT); else n_pass++;
    n_total++; if (got !== {2'b01, 32'h0000_0007}) $display("FAIL mid_data: got %h expected %h", got, {2'b01, 32'h0000_0007}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_signed_ovf();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
